// File: rtl/cs_cfg_seq.sv
// Headstage configuration sequencer: snapshots reg00..reg13 and regap on start and
// streams RHD-style WRITE commands; `define CS_CFG_CAL_EN appends CALIBRATE + dummy reads.
`timescale 1ns/1ps
module cs_cfg_seq #(
    parameter int N_AP    = 4,
    parameter int N_DUMMY = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [119:0] cfg_regs,
    input  logic [7:0]   cfg_ap,
    output logic         cmd_valid,
    input  logic         cmd_ready,
    output logic [15:0]  cmd_data,
    output logic         busy,
    output logic         done,
    output logic [4:0]   cmd_idx
);

    if (N_AP < 1 || N_AP > 8) begin : g_bad_ap
        $error("cs_cfg_seq: N_AP must be 1..8");
    end
    if (N_DUMMY < 1 || N_DUMMY > 15) begin : g_bad_dummy
        $error("cs_cfg_seq: N_DUMMY must be 1..15");
    end

    localparam logic [4:0]  LAST_WR  = 5'(13 + N_AP);
    localparam logic [15:0] CMD_CAL  = 16'h5500;
    localparam logic [15:0] CMD_DMY  = 16'hFF00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
`ifdef CS_CFG_CAL_EN
        S_CAL,
        S_DMY,
`endif
        S_FIN
    } state_t;

    state_t            state, state_nxt;
    logic [4:0]        idx_nxt;
    logic [13:0][7:0]  snap_reg;
    logic [7:0]        snap_ap;
    logic [7:0]        wr_data;

    // The top byte of cfg_regs has no register slot in the write sequence.
    logic unused_hi;
    assign unused_hi = ^cfg_regs[119:112];

`ifdef CS_CFG_CAL_EN
    localparam logic [3:0] LAST_DMY = 4'(N_DUMMY - 1);
    logic [3:0] dmy_cnt, dmy_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cmd_idx  <= '0;
            snap_reg <= '0;
            snap_ap  <= '0;
`ifdef CS_CFG_CAL_EN
            dmy_cnt  <= '0;
`endif
        end else begin
            state   <= state_nxt;
            cmd_idx <= idx_nxt;
`ifdef CS_CFG_CAL_EN
            dmy_cnt <= dmy_nxt;
`endif
            if (state == S_IDLE && start) begin
                snap_reg <= cfg_regs[111:0];
                snap_ap  <= cfg_ap;
            end
        end
    end

    always_comb begin
        wr_data = snap_ap;
        if (cmd_idx < 5'd14) wr_data = snap_reg[cmd_idx[3:0]];
    end

    // Outputs decode straight from registered state so an async reset drops cmd_valid at once.
    always_comb begin
        state_nxt = state;
        idx_nxt   = cmd_idx;
        cmd_valid = 1'b0;
        cmd_data  = 16'h0000;
        busy      = 1'b0;
        done      = 1'b0;
`ifdef CS_CFG_CAL_EN
        dmy_nxt   = dmy_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_WR;
                    idx_nxt   = '0;
                end
            end
            S_WR: begin
                busy      = 1'b1;
                cmd_valid = 1'b1;
                cmd_data  = {2'b10, 1'b0, cmd_idx, wr_data};
                if (cmd_ready) begin
                    idx_nxt = cmd_idx + 5'd1;
                    if (cmd_idx == LAST_WR) begin
`ifdef CS_CFG_CAL_EN
                        state_nxt = S_CAL;
`else
                        state_nxt = S_FIN;
`endif
                    end
                end
            end
`ifdef CS_CFG_CAL_EN
            S_CAL: begin
                busy      = 1'b1;
                cmd_valid = 1'b1;
                cmd_data  = CMD_CAL;
                if (cmd_ready) begin
                    idx_nxt   = cmd_idx + 5'd1;
                    dmy_nxt   = '0;
                    state_nxt = S_DMY;
                end
            end
            S_DMY: begin
                busy      = 1'b1;
                cmd_valid = 1'b1;
                cmd_data  = CMD_DMY;
                if (cmd_ready) begin
                    idx_nxt = cmd_idx + 5'd1;
                    dmy_nxt = dmy_cnt + 4'd1;
                    if (dmy_cnt == LAST_DMY) state_nxt = S_FIN;
                end
            end
`endif
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cs_cfg_seq.sv
// Directed self-checking bench for cs_cfg_seq; expectations adapt to whether
// CS_CFG_CAL_EN is defined (N_AP=4 with it, N_AP=8 without).
`timescale 1ns/1ps
module tb_cs_cfg_seq;

`ifdef CS_CFG_CAL_EN
    localparam int          N_AP      = 4;
    localparam int          N_DUMMY   = 9;
    localparam int          TOTAL     = 14 + N_AP + 1 + N_DUMMY;   // 28
    localparam logic [15:0] LAST_WORD = 16'h91FF;
`else
    localparam int          N_AP      = 8;
    localparam int          N_DUMMY   = 9;
    localparam int          TOTAL     = 14 + N_AP;                 // 22
    localparam logic [15:0] LAST_WORD = 16'h95FF;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [119:0] cfg_regs;
    logic [7:0]   cfg_ap;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [15:0]  cmd_data;
    logic         busy;
    logic         done;
    logic [4:0]   cmd_idx;

    int n_chk  = 0;
    int n_fail = 0;
    int done_cnt = 0;
    logic [7:0] base [14];

    cs_cfg_seq #(.N_AP(N_AP), .N_DUMMY(N_DUMMY)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_regs(cfg_regs), .cfg_ap(cfg_ap),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .busy(busy), .done(done), .cmd_idx(cmd_idx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [119:0] pack_regs();
        logic [119:0] r = '0;
        for (int i = 0; i < 14; i++) r[i*8 +: 8] = base[i];
        return r;
    endfunction

    function automatic logic [15:0] exp_cmd(input int i);
        logic [5:0] a = 6'(i);
        if (i < 14)        return {2'b10, a, base[i]};
        if (i < 14 + N_AP) return {2'b10, a, 8'hFF};
        if (i == 14 + N_AP) return 16'h5500;
        return 16'hFF00;
    endfunction

    // One configuration run; rst_at >= 0 aborts with a reset before that transfer.
    task automatic run_seq(input bit stall, input bit restart, input bit chg5, input int rst_at);
        int n = 0;
        int cyc = 0;
        int dn0 = done_cnt;
        bit hold_chk = 0;
        logic [15:0] hold = '0;
        cfg_regs = pack_regs();
        cfg_ap   = 8'hFF;
        cmd_ready = 1'b0;
        chk("idle_valid", cmd_valid, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("lat1_valid", cmd_valid, 1);
        chk("start_busy", busy, 1);
        chk("start_idx", cmd_idx, 0);
        if (chg5) cfg_regs[47:40] = 8'h79;
        while (n < TOTAL && cyc < 400) begin
            if (rst_at == n) begin
                rst_n = 1'b0;
                #1;
                chk("rst_valid", cmd_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_idx", cmd_idx, 0);
                tick();
                chk("rst_no_done", done_cnt, dn0);
                rst_n = 1'b1;
                tick();
                chk("rst_idle_busy", busy, 0);
                return;
            end
            start = restart && (n == 5);
            cmd_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            chk("valid_held", cmd_valid, 1);
            if (cmd_valid && cmd_ready) begin
                chk("data", cmd_data, exp_cmd(n));
                chk("idx", cmd_idx, n);
                if (n == 1) chk("reg01_word", cmd_data, 16'h8120);
                if (n == 13 + N_AP) chk("last_wr_word", cmd_data, LAST_WORD);
                if (chg5 && n == 5) chk("snap_reg05", cmd_data, 16'h8500);
                n++;
                hold_chk = 0;
            end else begin
                hold_chk = 1;
                hold = cmd_data;
            end
            tick();
            cyc++;
            if (hold_chk) begin
                chk("stall_data", cmd_data, hold);
                chk("stall_valid", cmd_valid, 1);
            end
        end
        start = 1'b0;
        cmd_ready = 1'b1;
        chk("n_xfers", n, TOTAL);
        chk("fin_done", done, 1);
        chk("fin_busy", busy, 0);
        chk("fin_valid", cmd_valid, 0);
        if (restart) start = 1'b1;
        tick();
        start = 1'b0;
        chk("post_done", done, 0);
        chk("post_valid", cmd_valid, 0);
        tick();
        chk("post_busy", busy, 0);
        chk("post_valid2", cmd_valid, 0);
        chk("one_done", done_cnt, dn0 + 1);
        cmd_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 14; i++) base[i] = 8'(i * 19 + 7);
        base[0] = 8'hDE;
        base[1] = 8'h20;
        base[5] = 8'h00;
        rst_n = 1'b0;
        start = 1'b0;
        cmd_ready = 1'b0;
        cfg_regs = pack_regs();
        cfg_ap = 8'h00;
        #12;
        chk("reset_valid", cmd_valid, 0);
        chk("reset_data", cmd_data, 16'h0000);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_idx", cmd_idx, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("first_word", exp_cmd(0), 16'h80DE);

        run_seq(0, 0, 0, -1);   // back-to-back
        run_seq(1, 0, 0, -1);   // random stalls
        run_seq(0, 1, 0, -1);   // start re-pulsed mid-run and in FIN
        run_seq(1, 0, 1, -1);   // inputs change after capture
        run_seq(0, 0, 0, 10);   // reset abort at transfer 10
        run_seq(1, 0, 0, -1);   // full run after abort

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cs_cfg_seq.md
Name: cs_cfg_seq

Overview:
- Sequences the headstage configuration produced by the register mapper (reg00..reg13, regap) into a stream of 16-bit RHD-style command words for the SPI command engine.
- Snapshots the register set on start. Issues WRITE commands for regs 0..13 and then the amplifier-power regs, optionally followed by CALIBRATE and dummy reads.
- Signals completion with a one-cycle done pulse.
- Sits between the cs register mapper and the SPI command serializer.

Parameters:
N_AP, 4, number of amplifier-power registers written with regap, at addresses 14..14+N_AP-1 (legal 1..8)
N_DUMMY, 9, number of dummy commands issued after CALIBRATE (legal 1..15)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request a configuration sequence; sampled only in IDLE
cfg_regs  in  120  {reg13,...,reg01,reg00}, with reg00 at [7:0]
cfg_ap  in  8  regap value
cmd_valid  out  1  cmd_data holds a valid command
cmd_ready  in  1  serializer accepts the command
cmd_data  out  16  command word
busy  out  1  sequence in progress
done  out  1  one-cycle pulse after the last command is accepted
cmd_idx  out  5  index of the current command within the sequence (for debug)

Behaviour:
- Reset (async assert, sync release) forces IDLE. All outputs go to 0: cmd_valid=0, cmd_data=16'h0000, busy=0, done=0, cmd_idx=0. The snapshot registers are cleared.
- Command encodings:
  - WRITE(a,d) = {2'b10, a[5:0], d}
  - CALIBRATE = 16'h5500
  - DUMMY = READ(63) = 16'hFF00
- States: IDLE -> WR -> CAL -> DMY -> FIN -> IDLE.
- IDLE:
  - busy=0, cmd_valid=0.
  - On start=1 at a rising edge: capture cfg_regs and cfg_ap into internal snapshots, set busy=1 and cmd_idx=0, enter WR.
  - cmd_valid rises in the cycle after start is sampled (latency 1).
- WR:
  - cmd_valid=1.
  - For idx 0..13: cmd_data = WRITE(idx, snap reg idx).
  - For idx 14..13+N_AP: cmd_data = WRITE(idx, snap_ap).
- Handshake:
  - A transfer occurs on any edge where cmd_valid & cmd_ready.
  - On a transfer, cmd_idx increments and cmd_data updates on the same edge, so cmd_valid stays high and back-to-back transfers run at one per cycle.
  - While cmd_ready=0, cmd_data and cmd_valid hold stable. cmd_valid never drops without a transfer.
- After the transfer at idx 13+N_AP: go to CAL if CS_CFG_CAL_EN is defined, otherwise go to FIN.
- CAL: cmd_data=16'h5500. On transfer go to DMY with the dummy counter at 0.
- DMY:
  - cmd_data=16'hFF00.
  - The counter increments on each transfer.
  - After the N_DUMMY-th transfer go to FIN.
- FIN (one cycle): cmd_valid=0, done=1, busy=0. Next state is IDLE.
  - A start asserted during FIN is ignored.
- start while busy=1 is ignored and is not queued.
- Input changes after capture do not affect the running sequence. Only the snapshot is used.
- Reset mid-sequence aborts immediately: cmd_valid drops asynchronously, and done is not pulsed.
- cmd_idx counts every command including CAL and the dummies. Total count is 14+N_AP, or 14+N_AP+1+N_DUMMY with the macro. Defaults give 18 and 28; 28 < 32, so 5 bits suffice.

Optional Feature:
CS_CFG_CAL_EN
- Defined: after the register writes, issue one CALIBRATE (16'h5500) followed by N_DUMMY dummy commands (16'hFF00).
- Not defined: the CAL and DMY states and the dummy counter are compiled out. FIN follows the last WRITE directly, and the sequence is 14+N_AP commands.

Test Plan:
1. Defaults, macro defined, cmd_ready tied to 1, reg01=8'h20, cfg_ap=8'hFF, pulse start.
   - Expect cmd_valid 1 cycle after start.
   - Expect 28 consecutive transfers: 16'h80DE (assuming reg00=DE), 16'h8120, ..., then 16'h8EFF, 16'h8FFF, 16'h90FF, 16'h91FF, then 16'h5500, then 9×16'hFF00.
   - Expect a done pulse 1 cycle after the last transfer, with busy low in that cycle.
2. Random cmd_ready stalls (about 50% duty).
   - Identical command sequence.
   - cmd_data stable and cmd_valid held through every stall.
   - Exactly 28 transfers.
3. start pulsed again at transfer 5 and during FIN.
   - Sequence unaffected, no second sequence runs, one done pulse only.
4. Change cfg_regs (reg05 from 8'h00 to 8'h79) one cycle after start.
   - WRITE to reg 5 is still 16'h8500, from the snapshot.
5. Assert rst_n low at transfer 10.
   - cmd_valid, busy, done and cmd_idx all 0 immediately, with no done pulse.
   - After release, a new start produces a full sequence from idx 0.
6. Macro undefined, N_AP=8.
   - Exactly 22 WRITE transfers ending in 16'h95FF.
   - No 16'h5500 or 16'hFF00 appears.
   - done pulses after the 22nd transfer.
